// File: rtl/cl_sde_stm.sv
// SDE stream transmit master: CSR-loaded 512b beats are queued in a TX FIFO and
// drained onto an AXI-Stream output through a 1-deep registered output stage.
module cl_sde_stm #(
  parameter int unsigned PTR_WIDTH = 9
) (
  input  logic         clk,
  input  logic         sync_rst,
  input  logic [11:0]  cfg_stm_addr,
  input  logic         cfg_stm_wr,
  input  logic         cfg_stm_rd,
  input  logic [31:0]  cfg_stm_wdata,
  output logic         stm_cfg_ack,
  output logic [31:0]  stm_cfg_rdata,
  output logic         stm_valid,
  output logic [511:0] stm_data,
  output logic [63:0]  stm_keep,
  output logic [63:0]  stm_user,
  output logic         stm_last,
  input  logic         stm_ready
);
  localparam int unsigned FIFO_WIDTH = 641;
  localparam int unsigned PAY_W      = FIFO_WIDTH - 1;
  localparam int unsigned PW         = PTR_WIDTH + 1;
  localparam int unsigned DEPTH      = 2 ** PTR_WIDTH;

  localparam logic [11:0] A_CTRL    = 12'h000;
  localparam logic [11:0] A_RST     = 12'h004;
  localparam logic [11:0] A_PTRS    = 12'h008;
  localparam logic [11:0] A_STAT    = 12'h00C;
  localparam logic [11:0] A_BEAT_LO = 12'h010;
  localparam logic [11:0] A_BEAT_HI = 12'h014;
  localparam logic [11:0] A_PKT_LO  = 12'h018;
  localparam logic [11:0] A_PKT_HI  = 12'h01C;
  localparam logic [11:0] A_KEEP_LO = 12'h140;
  localparam logic [11:0] A_KEEP_HI = 12'h144;
  localparam logic [11:0] A_USER_LO = 12'h148;
  localparam logic [11:0] A_USER_HI = 12'h14C;
  localparam logic [11:0] A_PUSH    = 12'h150;

  logic [1:0]        ctrl_q, ctrl_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cpc_q, cpc_d;
  logic              mid_q, mid_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic [63:0]       beats_q, beats_d, pkts_q, pkts_d;
  logic [15:0][31:0] stg_data_q, stg_data_d;
  logic [63:0]       stg_keep_q, stg_keep_d, stg_user_q, stg_user_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d, rd_mux;
  logic [PAY_W-1:0]  stage_pay_q;

  logic [PAY_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  last_mem;

  logic [PTR_WIDTH-1:0] wr_addr, rd_addr;
  logic [PW-1:0]     fill;
  logic              full, empty, hs, wr_hit_push, push_acc, fifo_rst, head_last, load, stg_hit;

  assign wr_addr     = wr_ptr_q[PTR_WIDTH-1:0];
  assign rd_addr     = rd_ptr_q[PTR_WIDTH-1:0];
  assign fill        = wr_ptr_q - rd_ptr_q;
  assign full        = (fill == PW'(DEPTH));
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign hs          = valid_q && stm_ready;
  assign wr_hit_push = cfg_stm_wr && (cfg_stm_addr == A_PUSH);
  assign push_acc    = wr_hit_push && !full;
  assign fifo_rst    = cfg_stm_wr && (cfg_stm_addr == A_RST) && cfg_stm_wdata[0];
  assign stg_hit     = (cfg_stm_addr[11:6] == 6'h04) && (cfg_stm_addr[1:0] == 2'b00);
  // Last flags live in flops so the packet gate sees the head beat's last in the load cycle
  assign head_last   = last_mem[rd_addr];
  assign load        = (!valid_q || stm_ready) && !empty && ctrl_q[0] && !fifo_rst &&
                       (!ctrl_q[1] || (cpc_q != '0) || mid_q);

  always_comb begin
    rd_mux = '0;
    case (cfg_stm_addr)
      A_CTRL:    rd_mux = 32'(ctrl_q);
      A_PTRS:    rd_mux = {16'(wr_ptr_q), 16'(rd_ptr_q)};
      A_STAT:    rd_mux = {29'd0, full, empty, ovf_q};
      A_BEAT_LO: rd_mux = beats_q[31:0];
      A_BEAT_HI: rd_mux = beats_q[63:32];
      A_PKT_LO:  rd_mux = pkts_q[31:0];
      A_PKT_HI:  rd_mux = pkts_q[63:32];
      A_KEEP_LO: rd_mux = stg_keep_q[31:0];
      A_KEEP_HI: rd_mux = stg_keep_q[63:32];
      A_USER_LO: rd_mux = stg_user_q[31:0];
      A_USER_HI: rd_mux = stg_user_q[63:32];
      default:   if (stg_hit) rd_mux = stg_data_q[cfg_stm_addr[5:2]];
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q + PW'(push_acc);
    rd_ptr_d   = rd_ptr_q + PW'(load);
    cpc_d      = cpc_q;
    mid_d      = mid_q;
    valid_d    = valid_q;
    last_d     = last_q;
    beats_d    = beats_q + 64'(hs);
    pkts_d     = pkts_q + 64'(hs && last_q);
    stg_data_d = stg_data_q;
    stg_keep_d = stg_keep_q;
    stg_user_d = stg_user_q;
    ack_d      = cfg_stm_wr || cfg_stm_rd;
    rdata_d    = cfg_stm_rd ? rd_mux : 32'd0;

    case ({push_acc && cfg_stm_wdata[0], load && head_last})
      2'b10:   cpc_d = cpc_q + PW'(1);
      2'b01:   cpc_d = cpc_q - PW'(1);
      default: cpc_d = cpc_q;
    endcase

    if (load) begin
      valid_d = 1'b1;
      last_d  = head_last;
      mid_d   = !head_last;
    end else if (hs) begin
      valid_d = 1'b0;
    end

    if (cfg_stm_wr) begin
      case (cfg_stm_addr)
        A_CTRL:    ctrl_d = cfg_stm_wdata[1:0];
        A_STAT:    if (cfg_stm_wdata[0]) ovf_d = 1'b0;
        A_BEAT_LO, A_BEAT_HI: beats_d = '0;
        A_PKT_LO,  A_PKT_HI:  pkts_d  = '0;
        A_KEEP_LO: stg_keep_d[31:0]  = cfg_stm_wdata;
        A_KEEP_HI: stg_keep_d[63:32] = cfg_stm_wdata;
        A_USER_LO: stg_user_d[31:0]  = cfg_stm_wdata;
        A_USER_HI: stg_user_d[63:32] = cfg_stm_wdata;
        A_PUSH:    if (full) ovf_d = 1'b1;
        default:   if (stg_hit) stg_data_d[cfg_stm_addr[5:2]] = cfg_stm_wdata;
      endcase
    end

    if (fifo_rst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cpc_d    = '0;
      mid_d    = 1'b0;
      valid_d  = 1'b0;
      last_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cpc_q      <= '0;
      mid_q      <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      beats_q    <= '0;
      pkts_q     <= '0;
      stg_data_q <= '0;
      stg_keep_q <= '0;
      stg_user_q <= '0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cpc_q      <= cpc_d;
      mid_q      <= mid_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      beats_q    <= beats_d;
      pkts_q     <= pkts_d;
      stg_data_q <= stg_data_d;
      stg_keep_q <= stg_keep_d;
      stg_user_q <= stg_user_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  // FIFO storage; payload read is registered straight into the output stage
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_addr]      <= {stg_user_q, stg_keep_q, stg_data_q};
      last_mem[wr_addr] <= cfg_stm_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst || fifo_rst) stage_pay_q <= '0;
    else if (load)            stage_pay_q <= mem[rd_addr];
  end

  assign stm_cfg_ack   = ack_q;
  assign stm_cfg_rdata = rdata_q;
  assign stm_valid     = valid_q;
  assign stm_last      = last_q;
  assign stm_data      = stage_pay_q[511:0];
  assign stm_keep      = stage_pay_q[575:512];
  assign stm_user      = stage_pay_q[639:576];

endmodule

// File: tb/tb_cl_sde_stm.sv
// Bench for cl_sde_stm: CSR-driven pushes against a queue model of the TX FIFO,
// with an output monitor checking beat order, payload and stall stability.
module tb_cl_sde_stm;
  logic         clk = 1'b0;
  logic         sync_rst;
  logic [11:0]  cfg_stm_addr;
  logic         cfg_stm_wr, cfg_stm_rd;
  logic [31:0]  cfg_stm_wdata;
  logic         stm_cfg_ack;
  logic [31:0]  stm_cfg_rdata;
  logic         stm_valid, stm_last, stm_ready;
  logic [511:0] stm_data;
  logic [63:0]  stm_keep, stm_user;

  cl_sde_stm dut (
    .clk(clk), .sync_rst(sync_rst), .cfg_stm_addr(cfg_stm_addr), .cfg_stm_wr(cfg_stm_wr),
    .cfg_stm_rd(cfg_stm_rd), .cfg_stm_wdata(cfg_stm_wdata), .stm_cfg_ack(stm_cfg_ack),
    .stm_cfg_rdata(stm_cfg_rdata), .stm_valid(stm_valid), .stm_data(stm_data),
    .stm_keep(stm_keep), .stm_user(stm_user), .stm_last(stm_last), .stm_ready(stm_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         last;
    logic [63:0]  user;
    logic [63:0]  keep;
    logic [511:0] data;
  } beat_t;

  beat_t             mq[$];
  logic [15:0][31:0] stg_dat;
  logic [63:0]       stg_keep, stg_user;
  logic [63:0]       exp_beats, exp_pkts;
  logic              exp_ovf;
  int                n_chk = 0, n_err = 0;
  int                cyc = 0, hs_first = 0, hs_last = 0;
  bit                burst_seen = 1'b0;
  int                ready_mode = 0;
  logic              ready_fix = 1'b0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Ready generator: fixed, toggling or random, applied just after each edge
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       stm_ready = ready_fix;
      1:       stm_ready = ~stm_ready;
      default: stm_ready = 1'($urandom);
    endcase
  end

  // Output monitor: in-order payload against the model, payload held while stalled
  logic         prev_stall = 1'b0, prev_flush = 1'b0;
  logic [511:0] prev_data;
  logic [128:0] prev_side;
  always @(negedge clk) begin
    beat_t b;
    if (prev_stall && !prev_flush) begin
      chk("hold_valid", 512'(stm_valid), 512'(1));
      chk("hold_data", stm_data, prev_data);
      chk("hold_side", 512'({stm_last, stm_user, stm_keep}), 512'(prev_side));
    end
    if (!sync_rst && stm_valid && stm_ready) begin
      if (mq.size() == 0) chk("spurious_beat", 512'(1), 512'(0));
      else begin
        b = mq.pop_front();
        chk("beat_data", stm_data, b.data);
        chk("beat_side", 512'({stm_last, stm_user, stm_keep}), 512'({b.last, b.user, b.keep}));
      end
      if (!burst_seen) begin
        hs_first   = cyc;
        burst_seen = 1'b1;
      end
      hs_last = cyc;
    end
    prev_stall = stm_valid && !stm_ready && !sync_rst;
    prev_flush = sync_rst || (cfg_stm_wr && cfg_stm_addr == 12'h004 && cfg_stm_wdata[0]);
    prev_data  = stm_data;
    prev_side  = {stm_last, stm_user, stm_keep};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] v);
    cfg_stm_addr  = a;
    cfg_stm_wdata = v;
    cfg_stm_wr    = 1'b1;
    tick();
    cfg_stm_wr = 1'b0;
    chk("wr_ack", 512'(stm_cfg_ack), 512'(1));
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    cfg_stm_addr = a;
    cfg_stm_rd   = 1'b1;
    tick();
    cfg_stm_rd = 1'b0;
    chk({tag, "_ack"}, 512'(stm_cfg_ack), 512'(1));
    chk(tag, 512'(stm_cfg_rdata), 512'(exp));
  endtask

  task automatic stg_wr(input logic [11:0] a, input logic [31:0] v);
    if (a >= 12'h100 && a < 12'h140) stg_dat[a[5:2]] = v;
    else if (a == 12'h140) stg_keep[31:0]  = v;
    else if (a == 12'h144) stg_keep[63:32] = v;
    else if (a == 12'h148) stg_user[31:0]  = v;
    else if (a == 12'h14C) stg_user[63:32] = v;
    csr_wr(a, v);
  endtask

  function automatic logic [11:0] stg_addr(input int k);
    return (k < 16) ? 12'(12'h100 + 4 * k) : 12'(12'h140 + 4 * (k - 16));
  endfunction

  task automatic rand_stage();
    for (int k = 0; k < 20; k++) stg_wr(stg_addr(k), $urandom);
  endtask

  // Model push: accepted while fewer than 512 beats are queued (stage assumed empty near full)
  task automatic push(input logic last);
    beat_t b;
    b.data = stg_dat;
    b.keep = stg_keep;
    b.user = stg_user;
    b.last = last;
    if (mq.size() < 512) begin
      mq.push_back(b);
      exp_beats = exp_beats + 64'd1;
      if (last) exp_pkts = exp_pkts + 64'd1;
    end else exp_ovf = 1'b1;
    csr_wr(12'h150, 32'(last));
  endtask

  task automatic flush_model();
    foreach (mq[i]) begin
      exp_beats = exp_beats - 64'd1;
      if (mq[i].last) exp_pkts = exp_pkts - 64'd1;
    end
    mq.delete();
  endtask

  task automatic clr_ctr();
    csr_wr(12'h010, 32'd0);
    csr_wr(12'h01C, 32'd0);
    exp_beats = '0;
    exp_pkts  = '0;
  endtask

  task automatic chk_ctr(input string tag);
    rd_chk({tag, "_beats_lo"}, 12'h010, exp_beats[31:0]);
    rd_chk({tag, "_beats_hi"}, 12'h014, exp_beats[63:32]);
    rd_chk({tag, "_pkts_lo"},  12'h018, exp_pkts[31:0]);
    rd_chk({tag, "_pkts_hi"},  12'h01C, exp_pkts[63:32]);
  endtask

  function automatic logic [31:0] model_stat();
    return {29'd0, mq.size() == 512, mq.size() == 0, exp_ovf};
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (mq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_left"}, 512'(mq.size()), 512'(0));
    repeat (3) tick();
  endtask

  initial begin
    sync_rst = 1'b1; cfg_stm_addr = '0; cfg_stm_wr = 1'b0; cfg_stm_rd = 1'b0; cfg_stm_wdata = '0;
    stm_ready = 1'b0;
    stg_dat = '0; stg_keep = '0; stg_user = '0;
    exp_beats = '0; exp_pkts = '0; exp_ovf = 1'b0;
    repeat (3) tick();
    sync_rst = 1'b0;

    // reset state
    chk("rst_valid", 512'(stm_valid), 512'(0));
    chk("rst_ack", 512'(stm_cfg_ack), 512'(0));
    chk("rst_rdata", 512'(stm_cfg_rdata), 512'(0));
    chk("rst_data", stm_data, 512'(0));
    chk("rst_last", 512'(stm_last), 512'(0));
    rd_chk("rst_ctrl", 12'h000, 32'd0);
    rd_chk("rst_ptrs", 12'h008, 32'd0);
    rd_chk("rst_stat", 12'h00C, model_stat());

    // 1: four back-to-back beats, first valid two cycles after push
    ready_fix = 1'b1;
    rand_stage();
    rd_chk("stg_rb_d5", 12'h114, stg_dat[5]);
    rd_chk("stg_rb_keep_hi", 12'h144, stg_keep[63:32]);
    rd_chk("stg_rb_user_lo", 12'h148, stg_user[31:0]);
    csr_wr(12'h000, 32'd1);
    burst_seen = 1'b0;
    push(1'b0);
    chk("lat_n1", 512'(stm_valid), 512'(0));
    push(1'b0);
    chk("lat_n2", 512'(stm_valid), 512'(1));
    push(1'b0);
    push(1'b1);
    wait_drain("t1", 50);
    chk("t1_b2b_span", 512'(hs_last - hs_first), 512'(3));
    chk_ctr("t1");

    // 2: packet mode holds an incomplete packet
    clr_ctr();
    csr_wr(12'h000, 32'd3);
    for (int i = 0; i < 3; i++) begin
      stg_wr(12'h100, 32'(i));
      push(1'b0);
    end
    repeat (6) tick();
    chk("t2_pkt_hold", 512'(stm_valid), 512'(0));
    stg_wr(12'h100, 32'd3);
    push(1'b1);
    wait_drain("t2a", 50);
    stg_wr(12'h100, 32'd4);
    push(1'b0);
    repeat (6) tick();
    chk("t2_cpc_zero_hold", 512'(stm_valid), 512'(0));
    push(1'b1);
    wait_drain("t2b", 50);
    chk_ctr("t2");

    // 3: ready toggling every cycle over an 8-beat packet
    csr_wr(12'h000, 32'd0);
    clr_ctr();
    for (int i = 0; i < 8; i++) begin
      stg_wr(12'h100, $urandom);
      push(i == 7);
    end
    ready_mode = 1;
    csr_wr(12'h000, 32'd1);
    wait_drain("t3", 100);
    ready_mode = 0;
    repeat (2) tick();
    chk_ctr("t3");

    // random staging updates, random last flags, random ready
    clr_ctr();
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 3)) stg_wr(stg_addr(int'($urandom_range(0, 19))), $urandom);
      push(i == 39 || $urandom_range(0, 3) == 0);
    end
    wait_drain("rnd", 1000);
    ready_mode = 0;
    repeat (2) tick();
    chk_ctr("rnd");

    // 4: overflow at depth+1 then full drain
    csr_wr(12'h000, 32'd0);
    csr_wr(12'h004, 32'd1);
    clr_ctr();
    for (int i = 0; i < 513; i++) begin
      stg_wr(12'h100, 32'(i));
      push(i % 64 == 63);
    end
    rd_chk("t4_stat_full", 12'h00C, model_stat());
    rd_chk("t4_ptrs_full", 12'h008, 32'h0200_0000);
    csr_wr(12'h00C, 32'd1);
    exp_ovf = 1'b0;
    rd_chk("t4_stat_w1c", 12'h00C, model_stat());
    csr_wr(12'h000, 32'd1);
    wait_drain("t4", 1500);
    rd_chk("t4_stat_empty", 12'h00C, model_stat());
    rd_chk("t4_ptrs_wrap", 12'h008, 32'h0200_0200);
    chk_ctr("t4");

    // 5: clearing go holds the pending beat, then FIFO reset
    clr_ctr();
    ready_fix = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stg_wr(12'h100, $urandom);
      push(i == 2);
    end
    repeat (3) tick();
    chk("t5_valid_pending", 512'(stm_valid), 512'(1));
    csr_wr(12'h000, 32'd0);
    repeat (2) tick();
    chk("t5_valid_held", 512'(stm_valid), 512'(1));
    ready_fix = 1'b1;
    tick();
    ready_fix = 1'b0;
    chk("t5_valid_after_one", 512'(stm_valid), 512'(0));
    repeat (3) tick();
    chk("t5_no_reload", 512'(stm_valid), 512'(0));
    flush_model();
    csr_wr(12'h004, 32'd1);
    rd_chk("t5_ptrs", 12'h008, 32'd0);
    rd_chk("t5_stat", 12'h00C, model_stat());
    chk_ctr("t5");

    // 6: sync_rst mid-packet
    csr_wr(12'h000, 32'd1);
    push(1'b0);
    push(1'b0);
    repeat (3) tick();
    chk("t6_valid_pre", 512'(stm_valid), 512'(1));
    sync_rst = 1'b1;
    flush_model();
    tick();
    sync_rst = 1'b0;
    exp_beats = '0; exp_pkts = '0; exp_ovf = 1'b0;
    stg_dat = '0; stg_keep = '0; stg_user = '0;
    chk("t6_valid", 512'(stm_valid), 512'(0));
    chk("t6_data", stm_data, 512'(0));
    chk("t6_side", 512'({stm_last, stm_user, stm_keep}), 512'(0));
    rd_chk("t6_ptrs", 12'h008, 32'd0);
    rd_chk("t6_ctrl", 12'h000, 32'd0);
    rd_chk("t6_stat", 12'h00C, model_stat());
    rd_chk("t6_stg_d0", 12'h100, 32'd0);
    chk_ctr("t6");
    rd_chk("t6_unmapped", 12'h3F0, 32'd0);
    tick();
    chk("t6_ack_drop", 512'(stm_cfg_ack), 512'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
